// File: rtl/sig_pkg.sv
// Shared constants and the bias/saturation helper for the signal separator's
// converter paths. The ADC front end strips the same bias this adds back.
package sig_pkg;

  localparam int DATA_W = 10;

  localparam logic [DATA_W-1:0] DAC_MIDSCALE = 10'd512;
  localparam logic [DATA_W-1:0] DAC_MAX_CODE = {DATA_W{1'b1}};

  typedef logic [DATA_W-1:0] dac_code_t;

  // Adds an unsigned bias to a signed sample. The sum is two bits wider than
  // the sample so it can never wrap. It is then clamped to 0..2^DATA_W-1.
  function automatic dac_code_t sat_add_bias(input logic signed [DATA_W-1:0] sample,
                                             input logic [DATA_W-1:0] bias);
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W+1:0] max_code;
    sum      = {{2{sample[DATA_W-1]}}, sample} + {2'b00, bias};
    max_code = {2'b00, DAC_MAX_CODE};
    if (sum < 0)
      return '0;
    else if (sum > max_code)
      return DAC_MAX_CODE;
    else
      return sum[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dac_tx_if.sv
// Sample stream into the DAC driver. This is a valid/ready handshake that
// carries one signed, zero-centred sample per transfer.
interface dac_tx_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dac_tx_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO. dout shows the head entry
// whenever the FIFO is not empty. DEPTH must be a power of two and at least 2.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array. It needs no reset because level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers and occupancy. A simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dac_tx.sv
// Streaming driver for the parallel DAC. It buffers incoming samples and
// releases one every DIV clocks. Each released sample gets the DC bias added
// back and is saturated. The block also produces the DAC latch clock.
// DIV must be even and at least 2. FIFO_DEPTH must be a power of two.
module dac_tx
  import sig_pkg::*;
#(
  parameter int                DATA_W     = sig_pkg::DATA_W,
  parameter logic [DATA_W-1:0] DC_BIAS    = DAC_MIDSCALE,
  parameter int                DIV        = 4,
  parameter int                FIFO_DEPTH = 4,
  localparam int               LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  dac_tx_if.slave           s,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_clk,
  output logic              underrun,
  output logic [LVL_W-1:0]  level
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              tick;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic [DATA_W-1:0] head;

  assign s.ready  = !rst && !fifo_full;
  assign push     = s.valid && s.ready;
  assign tick     = (cnt == CNT_W'(DIV - 1));
  assign cnt_next = tick ? '0 : cnt + 1'b1;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (tick),
    .din   (s.data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Rate counter, output code, latch clock and underrun flag. All of them are
  // registered so that nothing combinational reaches the DAC pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dac_data <= DC_BIAS;
      dac_clk  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dac_clk  <= (cnt_next >= CNT_W'(DIV / 2));
      underrun <= tick && fifo_empty;
      if (tick && !fifo_empty)
        dac_data <= sat_add_bias($signed(head), DC_BIAS);
    end
  end

endmodule

// File: doc/dac_tx.md
# dac_tx

Output-side streaming driver for the parallel 10-bit DAC in the signal separator's reconstruction path. It accepts zero-centred two's-complement samples through a valid/ready handshake and buffers them in a small FIFO. Samples are released at a fixed rate of one per DIV clocks. Each released sample has the DC bias added back and is saturated to the DAC's unsigned range. The block also generates the DAC's latch clock.

## Interface
- DATA_W, 10: sample width, input and output.
- DC_BIAS, 10'd512: unsigned offset added to every sample. Also the midscale value driven at reset.
- DIV, 4: clocks per DAC update. Must be even and ≥ 2.
- FIFO_DEPTH, 4: input buffer entries. Must be a power of two.
- clk  in  1  system clock; every register in the block is clocked on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_data  in  DATA_W  signed sample, zero-centred.
- s_valid  in  1  s_data is valid this cycle.
- s_ready  out  1  block can accept a sample this cycle.
- dac_data  out  DATA_W  unsigned DAC code, registered.
- dac_clk  out  1  DAC latch clock, registered. The DAC latches on its rising edge.
- underrun  out  1  one-cycle pulse when an update slot finds the FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO
  - A push happens when s_valid && s_ready.
  - s_ready = !rst && (level < FIFO_DEPTH). It is combinational from level and does not look ahead at a same-cycle pop.
  - Order is strictly first-in, first-out.
- Rate counter
  - cnt counts 0..DIV-1 and wraps.
  - tick = (cnt == DIV-1).
- On a tick with the FIFO non-empty:
  - Pop the head entry.
  - sum = sign-extend(head, DATA_W+2) + zero-extend(DC_BIAS, DATA_W+2).
  - If sum < 0, write 0 to dac_data.
  - If sum > 2^DATA_W-1, write 2^DATA_W-1.
  - Otherwise write sum[DATA_W-1:0].
  - dac_data updates at the clock edge that ends the tick cycle.
- On a tick with the FIFO empty:
  - dac_data holds its previous value.
  - underrun = 1 for the cycle after the tick. Otherwise underrun is 0.
- Push on an empty FIFO in a tick cycle: there is no bypass. The pop sees the FIFO as empty, underrun fires, and the sample waits for the next tick.
- Push and pop in the same cycle (FIFO non-empty and not full): level is unchanged.
- dac_clk = 1 exactly in cycles where cnt ≥ DIV/2, and 0 otherwise.
  - Falling edge coincides with the dac_data change.
  - Rising edge comes DIV/2 cycles later, mid-period, with data stable.
- Reset values:
  - cnt = 0, FIFO empty, level = 0.
  - dac_data = DC_BIAS.
  - dac_clk = 0, underrun = 0.
  - s_ready = 0 while rst is high.
- Reset mid-operation:
  - Buffered samples are discarded.
  - A sample offered during reset is not accepted.
  - Normal operation resumes on the first cycle after rst falls, with cnt = 0.

## Timing
- First tick comes DIV cycles after rst falls.
- Latency from push to dac_data change:
  - Minimum 1 cycle: the sample is pushed into an empty FIFO in the cycle just before a tick cycle.
  - Maximum DIV cycles when the FIFO is empty at push time.
  - Plus (level at push) × DIV cycles when other samples are queued ahead of it.
- dac_data is stable for DIV cycles per update.
- dac_data and dac_clk come straight from registers, with no combinational path to the pins.
- Sustained throughput is one sample per DIV cycles. The upstream stage sees back-pressure through s_ready only.

## Structure
- Shared package `sig_pkg` holds:
  - DATA_W.
  - The DAC midscale constant.
  - The saturating function `sat_add_bias`. The ADC front end's bias-removal path uses the same constants.
- One sub-module, `sync_fifo`, with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - It is first-word-fall-through: dout shows the head entry whenever the FIFO is not empty.
- The top level contains the rate counter, the saturation stage, and the dac_clk and underrun registers.

## Test plan
- Reset, then no input for 3×DIV cycles:
  - dac_data = 512 throughout and dac_clk toggles with period DIV.
  - underrun pulses at cycles 4, 8 and 12 after reset release (DIV = 4).
- Push −1, 0, +1 back-to-back:
  - dac_data steps 511, 512, 513, each held for 4 cycles.
  - Each value is stable at the dac_clk rising edge.
- Saturation, run once with DC_BIAS = 512 and once with DC_BIAS = 380:
  - DC_BIAS = 512: +511 → 1023, −512 → 0.
  - DC_BIAS = 380: +511 → 891, −512 → 0, −380 → 0, −381 → 0.
- Hold s_valid high continuously:
  - level reaches 4 and s_ready drops.
  - After that, exactly one sample is accepted per 4 cycles, and every sample comes out in order with no loss or duplication.
- Push a sample in a tick cycle on an empty FIFO:
  - underrun fires and dac_data holds.
  - The sample appears DIV cycles later.
- Assert rst for 1 cycle with 3 samples queued:
  - level = 0 and dac_data = 512 on the next cycle.
  - None of the queued samples ever reach dac_data.
